apb_reg_slave: RTL
==================

Name: apb_reg_slave

Overview:
- APB3 completer (responder) register bank at the far end of the AHB-to-APB bridge; the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA drive it, and its PRDATA/PREADY/PSLVERR return to the bridge.
- Provides NUM_REGS-1 read/write registers plus one read-only status register. Inserts a programmable number of wait states and flags errors for illegal accesses.
- Runs on the AHB clock; APB timing is qualified by PCLKEN.

Parameters:
- ADDRWIDTH, 16, APB address width.
- DATAWIDTH, 32, APB data width (multiple of 8, >=32).
- NUM_REGS, 8, total registers including status (2..64).
- WAIT_CYCLES, 1, PCLKEN-qualified access cycles with PREADY=0 before completion (0..15).

Ports:
- HCLK  in  1  clock (same clock as bridge)
- HRESETn  in  1  asynchronous active-low reset
- PCLKEN  in  1  APB clock enable; all state advances only when 1
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PADDR  in  ADDRWIDTH  byte address
- PWRITE  in  1  1=write, 0=read
- PWDATA  in  DATAWIDTH  write data
- PRDATA  out  DATAWIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only with PREADY

Behaviour:
- Clock/reset: single clock HCLK. Reset is asynchronous, active-low HRESETn (already decided).
- Reset values: state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all registers 0, counters 0.
- Address decode: idx = PADDR[ADDRWIDTH-1:2].
  - err = (PADDR[1:0]!=0) | (idx>=NUM_REGS) | (PWRITE & idx==NUM_REGS-1).
  - Decode is captured in the setup phase.
- FSM states: IDLE, ACCESS.
  - IDLE: when PCLKEN & PSEL & !PENABLE, latch idx, PWRITE, PWDATA and err; load wcnt=WAIT_CYCLES; go to ACCESS. Otherwise stay.
  - ACCESS, PCLKEN & PSEL & PENABLE & wcnt!=0: wcnt decrements.
  - ACCESS, PCLKEN & PSEL & PENABLE & wcnt==0: transfer completes this edge. Commit the write if !err, update counters, go to IDLE.
  - ACCESS, PCLKEN & !PSEL (protocol abort): go to IDLE. No commit, no counter update.
  - !PCLKEN: hold everything.
- Outputs (combinational from state):
  - PREADY = (state==ACCESS) & (wcnt==0).
  - PSLVERR = PREADY & err_latched.
  - PRDATA = register[idx_latched] when PREADY & !PWRITE_latched & !err_latched; otherwise 0.
- Latency: with WAIT_CYCLES=N, the access phase lasts N+1 PCLKEN cycles. Back-to-back transfers are accepted: a new setup is recognised in the cycle following completion.
- Write commit: full word written at the completing edge. Reads have no side effects.
- Status register (idx NUM_REGS-1, read-only):
  - [15:0] completed error-free writes, wraps 0xFFFF->0.
  - [31:16] error responses, saturates at 0xFFFF.
  - Upper bits read 0 when DATAWIDTH>32.
  - Read of status returns the value before any same-edge update.
- Reset asserted mid-transfer: immediate return to reset values; the pending write is discarded.
- PADDR/PWDATA changes after setup are ignored; only latched values are used.

Optional Feature:
- Macro: APB_SLV_PSTRB_EN.
- When defined:
  - Adds input PSTRB, width DATAWIDTH/8 (APB4 byte strobes), latched in setup.
  - Writes update only bytes whose strobe is 1.
  - A write with PSTRB==0 completes without error and does not change the data register, but still increments the write count.
  - Read transfers ignore PSTRB.
- When undefined: no PSTRB port; every write updates the full word.

Test Plan:
- Reset then write 0xDEADBEEF to 0x0004 with WAIT_CYCLES=1 -> PREADY low for 1 access cycle, then high; PSLVERR=0. Read 0x0004 returns 0xDEADBEEF. Status reads 0x00000001.
- Read 0x0020 with NUM_REGS=8 (idx 8, out of range) -> PREADY then PSLVERR=1, PRDATA=0. Status[31:16] increments to 1.
- Write to status 0x001C and to misaligned 0x0002 -> both PSLVERR=1, no register change. Error count +2, write count unchanged.
- PCLKEN toggling 1-0-1 during a WAIT_CYCLES=3 access -> PREADY asserts only after 4 PCLKEN-high access cycles. No state change in PCLKEN=0 cycles.
- Assert HRESETn=0 during the access phase of a write of 0x12345678 to 0x0008 -> outputs return to 0 asynchronously. A subsequent read of 0x0008 returns 0x00000000.
- APB_SLV_PSTRB_EN: write 0xAABBCCDD with PSTRB=0b0101 over 0x11223344 at 0x0000 -> read returns 0x11BB33DD.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the register
// bank (slave). PCLKEN travels with the bus because it qualifies every APB
// phase. The PSTRB byte strobes exist only when APB_SLV_PSTRB_EN is defined.
//
// Signals: PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA, [PSTRB]  (master -> slave)
//          PRDATA, PREADY, PSLVERR                                (slave -> master)
interface apb_reg_slave_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                   PCLKEN;
    logic                   PSEL;
    logic                   PENABLE;
    logic [ADDRWIDTH-1:0]   PADDR;
    logic                   PWRITE;
    logic [DATAWIDTH-1:0]   PWDATA;
`ifdef APB_SLV_PSTRB_EN
    logic [DATAWIDTH/8-1:0] PSTRB;
`endif
    logic [DATAWIDTH-1:0]   PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport master (
        output PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
`ifdef APB_SLV_PSTRB_EN
        output PSTRB,
`endif
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
`ifdef APB_SLV_PSTRB_EN
        input  PSTRB,
`endif
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB3 completer register bank: NUM_REGS-1 read/write registers followed by
// one read-only status register (error-free write count in [15:0], wrapping;
// error response count in [31:16], saturating). Each access phase holds
// PREADY low for WAIT_CYCLES PCLKEN-qualified cycles. Misaligned, out-of-range
// and status-write accesses complete with PSLVERR.
//
// Ports:
//   HCLK     clock shared with the bridge
//   HRESETn  asynchronous active-low reset
//   apb      slave modport of apb_reg_slave_if (PCLKEN/PSEL/PENABLE/PADDR/
//            PWRITE/PWDATA[/PSTRB] in, PRDATA/PREADY/PSLVERR out)
//
// Build option: APB_SLV_PSTRB_EN adds APB4 byte strobes on writes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer owned; waiting for a setup phase
// ACCESS | decode latched; counting wait states, completes at wcnt == 0
module apb_reg_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    apb_reg_slave_if.slave   apb
);
    localparam int IDXW = ADDRWIDTH - 2;
    localparam int NB   = DATAWIDTH / 8;
    localparam int NRW  = NUM_REGS - 1;
    localparam logic [IDXW-1:0] STATUS_IDX = IDXW'(NUM_REGS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]   regs_q [NRW];
    logic [DATAWIDTH-1:0]   regs_d [NRW];
    logic [15:0]            wr_cnt_q, wr_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATAWIDTH-1:0]   prdata_q, prdata_d;
    logic [NB-1:0]          wr_strb;

`ifdef APB_SLV_PSTRB_EN
    logic [NB-1:0]          strb_q, strb_d;
    assign wr_strb = strb_q;
`else
    assign wr_strb = '1;
`endif

    logic [IDXW-1:0]        setup_idx;
    logic                   setup_err;
    logic [DATAWIDTH-1:0]   rd_word;

    assign setup_idx = apb.PADDR[ADDRWIDTH-1:2];
    assign setup_err = (apb.PADDR[1:0] != 2'b00) ||
                       (setup_idx > STATUS_IDX) ||
                       (apb.PWRITE && (setup_idx == STATUS_IDX));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        regs_d    = regs_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
`ifdef APB_SLV_PSTRB_EN
        strb_d    = strb_q;
`endif
        if (apb.PCLKEN) begin
            case (state_q)
                IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        state_d = ACCESS;
                        wcnt_d  = 4'(WAIT_CYCLES);
                        idx_d   = setup_idx;
                        write_d = apb.PWRITE;
                        err_d   = setup_err;
                        wdata_d = apb.PWDATA;
`ifdef APB_SLV_PSTRB_EN
                        strb_d  = apb.PSTRB;
`endif
                    end
                end
                ACCESS: begin
                    if (!apb.PSEL) begin
                        // Master abandoned the transfer: drop it silently.
                        state_d = IDLE;
                    end else if (apb.PENABLE) begin
                        if (wcnt_q != 4'd0) begin
                            wcnt_d = wcnt_q - 4'd1;
                        end else begin
                            state_d = IDLE;
                            if (err_q) begin
                                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                            end else if (write_q) begin
                                wr_cnt_d = wr_cnt_q + 16'd1;
                                for (int i = 0; i < NRW; i++) begin
                                    if (idx_q == IDXW'(i)) begin
                                        for (int b = 0; b < NB; b++) begin
                                            if (wr_strb[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read mux uses current register/counter values: a completing edge always
    // returns to IDLE, so a registered read is never taken on an updating edge.
    always_comb begin
        rd_word = '0;
        if (idx_d == STATUS_IDX) begin
            rd_word = DATAWIDTH'({err_cnt_q, wr_cnt_q});
        end else begin
            for (int i = 0; i < NRW; i++) begin
                if (idx_d == IDXW'(i)) rd_word = regs_q[i];
            end
        end
    end

    // Outputs are registered from next-state so they match state/wcnt exactly.
    always_comb begin
        pready_d  = (state_d == ACCESS) && (wcnt_d == 4'd0);
        pslverr_d = pready_d && err_d;
        prdata_d  = (pready_d && !write_d && !err_d) ? rd_word : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            wcnt_q    <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            regs_q    <= '{default: '0};
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            regs_q    <= regs_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= strb_d;
`endif
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
endmodule
